// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid game datapath.
package asteroid_pkg;

    localparam int COORD_W     = 10;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int NUM_BULLETS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        COOL   = 2'd2
    } launch_state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw push button.
// Emits a one-cycle pulse on each accepted rising level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg, sync2_reg;
    logic          db_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            db_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES)) begin
                // New level has been stable long enough; accept it.
                db_reg   <= sync2_reg;
                rise_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/bullet_launcher.sv
// Fire controller: debounced press -> cooldown-gated launch into the lowest
// free bullet slot, with occupancy tracking from per-slot done pulses.
import asteroid_pkg::*;

module bullet_launcher #(
    parameter int NUM_SLOTS       = NUM_BULLETS,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COOLDOWN_MOVES  = 8,
    parameter int NOSE_OFFSET     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pixpulse,
    input  logic                 move,
    input  logic                 btn_fire,
    input  logic [COORD_W-1:0]   ship_x,
    input  logic [COORD_W-1:0]   ship_y,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [COORD_W-1:0]   fire_x,
    output logic [COORD_W-1:0]   fire_y,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [1:0]           bullet_count
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CD_W   = (COOLDOWN_MOVES > 0) ? $clog2(COOLDOWN_MOVES + 1) : 1;

    launch_state_t        state_reg, state_next;
    logic [SLOT_W-1:0]    slot_reg, slot_next;
    logic [COORD_W-1:0]   fire_x_reg, fire_x_next;
    logic [COORD_W-1:0]   fire_y_reg, fire_y_next;
    logic [CD_W-1:0]      cool_reg, cool_next;
    logic [NUM_SLOTS-1:0] busy_reg, busy_next;

    logic                 pending;
    logic                 launch_now;
    logic                 any_free;
    logic [SLOT_W-1:0]    free_idx;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fire_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_fire),
        .rise (pending)
    );

    // Lowest-index free slot wins.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign launch_now = (state_reg == LAUNCH) && pixpulse;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_fire
        assign fire[gi] = launch_now && (slot_reg == SLOT_W'(gi));
    end

    always_comb begin
        state_next  = state_reg;
        slot_next   = slot_reg;
        fire_x_next = fire_x_reg;
        fire_y_next = fire_y_reg;
        cool_next   = cool_reg;
        case (state_reg)
            IDLE: begin
                if (pending && any_free) begin
                    state_next  = LAUNCH;
                    slot_next   = free_idx;
                    fire_x_next = ship_x;
                    fire_y_next = (ship_y >= COORD_W'(NOSE_OFFSET)) ?
                                  ship_y - COORD_W'(NOSE_OFFSET) : '0;
                end
            end
            LAUNCH: begin
                if (pixpulse) begin
                    if (COOLDOWN_MOVES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = COOL;
                        cool_next  = CD_W'(COOLDOWN_MOVES);
                    end
                end
            end
            COOL: begin
                if (move) begin
                    cool_next = cool_reg - 1'b1;
                    if (cool_reg <= CD_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Releases and the launch set never target the same slot.
    assign busy_next = (busy_reg & ~slot_done) | fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            slot_reg   <= '0;
            fire_x_reg <= '0;
            fire_y_reg <= '0;
            cool_reg   <= '0;
            busy_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            slot_reg   <= slot_next;
            fire_x_reg <= fire_x_next;
            fire_y_reg <= fire_y_next;
            cool_reg   <= cool_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        bullet_count = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bullet_count = bullet_count + 2'(busy_reg[i]);
        end
    end

    assign fire_x    = fire_x_reg;
    assign fire_y    = fire_y_reg;
    assign slot_busy = busy_reg;

endmodule

// File: tb/tb_bullet_launcher.sv
// Scoreboard bench for bullet_launcher: stimulus pushes expected launches,
// a negedge monitor pops and compares each fire pulse.
module tb_bullet_launcher;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pixpulse = 1'b0;
    logic          move = 1'b0;
    logic          btn_fire = 1'b0;
    logic [9:0]    ship_x = '0;
    logic [9:0]    ship_y = '0;
    logic [NS-1:0] slot_done = '0;
    logic [NS-1:0] fire;
    logic [9:0]    fire_x;
    logic [9:0]    fire_y;
    logic [NS-1:0] slot_busy;
    logic [1:0]    bullet_count;

    bullet_launcher #(
        .NUM_SLOTS      (NS),
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_MOVES (2),
        .NOSE_OFFSET    (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixpulse    (pixpulse),
        .move        (move),
        .btn_fire    (btn_fire),
        .ship_x      (ship_x),
        .ship_y      (ship_y),
        .slot_done   (slot_done),
        .fire        (fire),
        .fire_x      (fire_x),
        .fire_y      (fire_y),
        .slot_busy   (slot_busy),
        .bullet_count(bullet_count)
    );

    typedef struct {
        logic [NS-1:0] f;
        logic [9:0]    x;
        logic [9:0]    y;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            moves_since = 99;
    bit            pix_en = 1'b1;
    logic [NS-1:0] busy_m = '0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pixel enable every 4 clocks, move every 40 (always on a pixel cycle).
    initial begin
        int pc = 0;
        forever begin
            @(posedge clk); #1;
            if (pix_en) begin
                pc++;
                pixpulse = (pc % 4 == 0);
                move     = (pc % 40 == 0);
            end else begin
                pixpulse = 1'b0;
                move     = 1'b0;
            end
        end
    end

    // Monitor: every fire pulse must match the next expected launch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                moves_since = 99;
            end else begin
                if (pixpulse && move) moves_since++;
                if (fire != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_fire", 32'(fire), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("fire_slot", 32'(fire), 32'(e.f));
                        check("fire_x", 32'(fire_x), 32'(e.x));
                        check("fire_y", 32'(fire_y), 32'(e.y));
                        check("fire_on_pixpulse", 32'(pixpulse), 32'd1);
                        $display("fire slot=%b x=%0d y=%0d", fire, fire_x, fire_y);
                    end
                    moves_since = 0;
                end
            end
        end
    end

    task automatic wait_move();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (move) found = 1'b1;
        end
        check("move_timeout", 32'(found), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_occ(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(slot_busy), 32'(busy_m));
        check({tag, "_count"}, 32'(bullet_count), 32'($countones(busy_m)));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fire"}, 32'(fire), 32'd0);
        check({tag, "_fire_x"}, 32'(fire_x), 32'd0);
        check({tag, "_fire_y"}, 32'(fire_y), 32'd0);
        check({tag, "_busy"}, 32'(slot_busy), 32'd0);
        check({tag, "_count"}, 32'(bullet_count), 32'd0);
    endtask

    // Press aligned just after a move so cooldown acceptance is unambiguous.
    task automatic press(input logic [9:0] x, input logic [9:0] y, input int hold);
        int   k = -1;
        bit   ok;
        exp_t e;
        wait_move();
        @(posedge clk); #1;
        ship_x = x;
        ship_y = y;
        for (int i = NS - 1; i >= 0; i--) if (!busy_m[i]) k = i;
        ok = (k >= 0) && (moves_since >= 2);
        if (ok) begin
            e.f = NS'(1) << k;
            e.x = x;
            e.y = (y >= 10'd12) ? y - 10'd12 : 10'd0;
            sb.push_back(e);
            busy_m[k] = 1'b1;
        end
        $display("press x=%0d y=%0d hold=%0d accept=%0d slot=%0d", x, y, hold, ok, k);
        btn_fire = 1'b1;
        repeat (hold) @(posedge clk);
        #1 btn_fire = 1'b0;
        repeat (14) @(posedge clk);
        drain();
    endtask

    task automatic release_slot(input int j);
        @(posedge clk); #1 slot_done = NS'(1) << j;
        @(posedge clk); #1 slot_done = '0;
        busy_m[j] = 1'b0;
        $display("release slot=%0d", j);
    endtask

    initial begin
        int r;
        // Reset state
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single press
        press(10'd320, 10'd240, 12);
        check_occ("single");

        // Glitch must not fire
        @(posedge clk); #1 btn_fire = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_fire = 1'b0;
        repeat (40) @(posedge clk);
        $display("glitch 3 clks");
        check_occ("glitch");

        // Long hold: exactly one fire
        repeat (100) @(posedge clk);
        press(10'd100, 10'd200, 200);
        repeat (60) @(posedge clk);
        check_occ("hold");

        // Fill all three slots, then a dropped fourth press
        release_slot(0);
        release_slot(1);
        for (int i = 0; i < 3; i++) begin
            repeat (90) @(posedge clk);
            press(10'($urandom_range(0, 639)), 10'($urandom_range(12, 479)), 12);
        end
        check_occ("full");
        repeat (90) @(posedge clk);
        press(10'd50, 10'd60, 12);
        check_occ("dropped_full");

        // Free one random slot, next press refills it
        r = $urandom_range(0, 2);
        release_slot(r);
        check_occ("freed");
        repeat (90) @(posedge clk);
        press(10'd400, 10'd300, 12);
        check_occ("refill");

        // Press during cooldown is dropped, after cooldown accepted
        release_slot(0);
        release_slot(1);
        release_slot(2);
        repeat (90) @(posedge clk);
        press(10'd10, 10'd20, 12);
        press(10'd11, 10'd21, 12);
        press(10'd12, 10'd22, 12);
        check_occ("cooldown");

        // Saturating nose offset
        release_slot(0);
        release_slot(1);
        press(10'd33, 10'd5, 12);
        press(10'd34, 10'd11, 12);
        check_occ("saturate");

        // Reset while waiting in LAUNCH: no fire pulse
        release_slot(0);
        release_slot(1);
        release_slot(2);
        pix_en = 1'b0;
        repeat (100) @(posedge clk);
        #1 ship_x = 10'd77;
        ship_y = 10'd88;
        btn_fire = 1'b1;
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid_launch_rst");
        btn_fire = 1'b0;
        busy_m = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        pix_en = 1'b1;
        repeat (60) @(posedge clk);
        check_occ("after_rst");

        // Randomized mix
        for (int n = 0; n < 16; n++) begin
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                press(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
                      $urandom_range(10, 40));
            end else if (r == 2) begin
                release_slot($urandom_range(0, 2));
                check_occ("rand_release");
            end else begin
                repeat ($urandom_range(0, 100)) @(posedge clk);
            end
        end
        repeat (20) @(posedge clk);
        check_occ("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
